// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and constants for the I2C target controller.
// Rev 1.0
`default_nettype none

package i2c_pkg;

  typedef enum logic {
    I2C_WRITE = 1'b0,
    I2C_READ  = 1'b1
  } i2c_op_t;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    ADDR     = 4'd1,
    ADDR_ACK = 4'd2,
    WR_DATA  = 4'd3,
    WR_ACK   = 4'd4,
    RD_LOAD  = 4'd5,
    RD_DATA  = 4'd6,
    RD_ACK   = 4'd7,
    IGNORE   = 4'd8
  } i2c_state_e;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

endpackage

`default_nettype wire

// File: rtl/i2c_target_ctrl_if.sv
// i2c_target_ctrl_if: open-drain bus pins plus RX/TX byte handshakes.
// Rev 1.0
`default_nettype none

interface i2c_target_ctrl_if #(
  parameter int unsigned I2C_DATA_WIDTH = 8
);
  logic                      scl_i;
  logic                      sda_i;
  logic                      scl_o;
  logic                      sda_o;
  logic [I2C_DATA_WIDTH-1:0] wr_data_o;
  logic                      wr_valid_o;
  logic                      wr_ready_i;
  logic [I2C_DATA_WIDTH-1:0] rd_data_i;
  logic                      rd_valid_i;
  logic                      rd_ready_o;

  modport master (
    output scl_i, sda_i, wr_ready_i, rd_data_i, rd_valid_i,
    input  scl_o, sda_o, wr_data_o, wr_valid_o, rd_ready_o
  );

  modport slave (
    input  scl_i, sda_i, wr_ready_i, rd_data_i, rd_valid_i,
    output scl_o, sda_o, wr_data_o, wr_valid_o, rd_ready_o
  );
endinterface

`default_nettype wire

// File: rtl/i2c_rx_fifo.sv
// i2c_rx_fifo: write-data FIFO with extra-MSB pointers; head reads as zero when empty.
// Rev 1.0
`default_nettype none

module i2c_rx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

`default_nettype wire

// File: rtl/i2c_target_ctrl.sv
// i2c_target_ctrl: 7-bit-address I2C target with RX FIFO, read clock stretching and overrun flag.
// Rev 1.0
`default_nettype none

module i2c_target_ctrl
  import i2c_pkg::*;
#(
  parameter int unsigned               I2C_ADDR_WIDTH = 7,
  parameter int unsigned               I2C_DATA_WIDTH = 8,
  parameter logic [I2C_ADDR_WIDTH-1:0] TARGET_ADDR    = 7'h22,
  parameter int unsigned               RX_DEPTH       = 4
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  i2c_target_ctrl_if.slave   bus,
  output i2c_op_t            op_o,
  output logic               busy_o,
  output logic               start_o,
  output logic               stop_o,
  output logic               overrun_o
);

  localparam int unsigned         CNT_W     = $clog2(I2C_DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0]    ADDR_LAST = CNT_W'(I2C_ADDR_WIDTH);
  localparam logic [CNT_W-1:0]    DATA_LAST = CNT_W'(I2C_DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0]    DATA_BITS = CNT_W'(I2C_DATA_WIDTH);

  logic scl_meta_q, scl_sync_q, scl_prev_q;
  logic sda_meta_q, sda_sync_q, sda_prev_q;

  i2c_state_e                state_q, state_d;
  logic [CNT_W-1:0]          bit_cnt_q, bit_cnt_d;
  logic [I2C_DATA_WIDTH-1:0] sr_q, sr_d;
  logic                      phase_q, phase_d;
  logic                      sda_q, sda_d;
  logic                      scl_q, scl_d;
  i2c_op_t                   op_q, op_d;
  logic                      busy_q, busy_d;
  logic                      overrun_q, overrun_d;
  logic                      rd_ready_q, rd_ready_d;
  logic                      start_q, start_d;
  logic                      stop_q, stop_d;

  logic scl_rise, scl_fall, start_det, stop_det;
  logic fifo_push, fifo_empty, fifo_full;

  assign scl_rise  =  scl_sync_q & ~scl_prev_q;
  assign scl_fall  = ~scl_sync_q &  scl_prev_q;
  // SCL must be high on both taps so SDA moving with our own SCL release is not a condition
  assign start_det = scl_sync_q & scl_prev_q & ~sda_sync_q &  sda_prev_q;
  assign stop_det  = scl_sync_q & scl_prev_q &  sda_sync_q & ~sda_prev_q;

  i2c_rx_fifo #(
    .WIDTH (I2C_DATA_WIDTH),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .push_i      (fifo_push),
    .push_data_i (sr_q),
    .pop_i       (bus.wr_ready_i),
    .pop_data_o  (bus.wr_data_o),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    sr_d       = sr_q;
    phase_d    = phase_q;
    sda_d      = sda_q;
    scl_d      = scl_q;
    op_d       = op_q;
    busy_d     = busy_q;
    overrun_d  = overrun_q;
    rd_ready_d = 1'b0;
    start_d    = start_det;
    stop_d     = stop_det;
    fifo_push  = 1'b0;

    if (stop_det) begin
      state_d = IDLE;
      phase_d = 1'b0;
      sda_d   = 1'b1;
      scl_d   = 1'b1;
      busy_d  = 1'b0;
    end else if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = '0;
      phase_d   = 1'b0;
      sda_d     = 1'b1;
      scl_d     = 1'b1;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise) begin
            sr_d      = {sr_q[I2C_DATA_WIDTH-2:0], sda_sync_q};
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == ADDR_LAST) begin
              bit_cnt_d = '0;
              phase_d   = 1'b0;
              if (sr_d[I2C_ADDR_WIDTH:1] == TARGET_ADDR) begin
                state_d = ADDR_ACK;
                busy_d  = 1'b1;
                op_d    = sr_d[0] ? I2C_READ : I2C_WRITE;
              end else begin
                state_d = IGNORE;
              end
            end
          end
        end
        // phase 0 waits for the fall ending bit 8, phase 1 for the fall ending bit 9
        ADDR_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              sda_d   = ACK;
              phase_d = 1'b1;
            end else begin
              sda_d   = NACK;
              phase_d = 1'b0;
              state_d = (op_q == I2C_READ) ? RD_LOAD : WR_DATA;
            end
          end
        end
        WR_DATA: begin
          if (scl_rise) begin
            sr_d      = {sr_q[I2C_DATA_WIDTH-2:0], sda_sync_q};
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == DATA_LAST) begin
              bit_cnt_d = '0;
              phase_d   = 1'b0;
              state_d   = WR_ACK;
            end
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              if (!fifo_full) begin
                fifo_push = 1'b1;
                sda_d     = ACK;
                phase_d   = 1'b1;
              end else begin
                overrun_d = 1'b1;
                state_d   = IGNORE;
              end
            end else begin
              sda_d   = NACK;
              phase_d = 1'b0;
              state_d = WR_DATA;
            end
          end
        end
        // entered with SCL low, so the MSB can be put on SDA right away
        RD_LOAD: begin
          if (bus.rd_valid_i) begin
            sr_d       = bus.rd_data_i;
            sda_d      = bus.rd_data_i[I2C_DATA_WIDTH-1];
            scl_d      = 1'b1;
            rd_ready_d = 1'b1;
            bit_cnt_d  = '0;
            state_d    = RD_DATA;
          end else begin
            scl_d = 1'b0;
          end
        end
        RD_DATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end else if (scl_fall) begin
            if (bit_cnt_q == DATA_BITS) begin
              sda_d   = 1'b1;
              phase_d = 1'b0;
              state_d = RD_ACK;
            end else begin
              sr_d  = {sr_q[I2C_DATA_WIDTH-2:0], 1'b0};
              sda_d = sr_q[I2C_DATA_WIDTH-2];
            end
          end
        end
        RD_ACK: begin
          if (scl_rise && !phase_q) begin
            if (sda_sync_q == NACK) state_d = IGNORE;
            else                    phase_d = 1'b1;
          end else if (scl_fall && phase_q) begin
            phase_d = 1'b0;
            state_d = RD_LOAD;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      sr_q       <= '0;
      phase_q    <= 1'b0;
      sda_q      <= 1'b1;
      scl_q      <= 1'b1;
      op_q       <= I2C_WRITE;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
      rd_ready_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      scl_meta_q <= bus.scl_i;
      scl_sync_q <= scl_meta_q;
      scl_prev_q <= scl_sync_q;
      sda_meta_q <= bus.sda_i;
      sda_sync_q <= sda_meta_q;
      sda_prev_q <= sda_sync_q;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      sr_q       <= sr_d;
      phase_q    <= phase_d;
      sda_q      <= sda_d;
      scl_q      <= scl_d;
      op_q       <= op_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
      rd_ready_q <= rd_ready_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
    end
  end

  assign bus.scl_o      = scl_q;
  assign bus.sda_o      = sda_q;
  assign bus.wr_valid_o = ~fifo_empty;
  assign bus.rd_ready_o = rd_ready_q;
  assign op_o           = op_q;
  assign busy_o         = busy_q;
  assign start_o        = start_q;
  assign stop_o         = stop_q;
  assign overrun_o      = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_target_ctrl.sv
// tb_i2c_target_ctrl: directed I2C controller model driving the target over an open-drain bus.
// Rev 1.0
`default_nettype none

module tb_i2c_target_ctrl;
  import i2c_pkg::*;

  localparam int Q = 8;

  logic    clk   = 1'b0;
  logic    rst_n = 1'b0;
  logic    scl_m = 1'b1;
  logic    sda_m = 1'b1;
  i2c_op_t op;
  logic    busy, start, stop, overrun;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int start_cnt = 0, stop_cnt = 0, rdy_cnt = 0, sda_low_cnt = 0;

  always #5 clk = ~clk;

  i2c_target_ctrl_if #(.I2C_DATA_WIDTH(8)) bus ();

  assign bus.scl_i = scl_m & bus.scl_o;
  assign bus.sda_i = sda_m & bus.sda_o;

  i2c_target_ctrl #(
    .I2C_ADDR_WIDTH (7),
    .I2C_DATA_WIDTH (8),
    .TARGET_ADDR    (7'h22),
    .RX_DEPTH       (4)
  ) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .bus       (bus),
    .op_o      (op),
    .busy_o    (busy),
    .start_o   (start),
    .stop_o    (stop),
    .overrun_o (overrun)
  );

  always @(posedge clk) begin
    if (start)              start_cnt   <= start_cnt + 1;
    if (stop)               stop_cnt    <= stop_cnt + 1;
    if (bus.rd_ready_o)     rdy_cnt     <= rdy_cnt + 1;
    if (bus.sda_o === 1'b0) sda_low_cnt <= sda_low_cnt + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time budget exceeded, observed no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic scl_high(output int stretch);
    stretch = 0;
    scl_m   = 1'b1;
    #1;
    while (bus.scl_i !== 1'b1 && stretch < 2000) begin
      @(negedge clk);
      stretch++;
    end
    if (bus.scl_i !== 1'b1) check("scl_release_timeout", 32'(bus.scl_i), 32'd1);
  endtask

  task automatic clock_bit(input logic b, output logic s, output int st);
    sda_m = b;
    wait_clks(Q);
    scl_high(st);
    wait_clks(Q);
    s = bus.sda_i;
    wait_clks(Q);
    scl_m = 1'b0;
    wait_clks(Q);
  endtask

  task automatic i2c_start();
    int st;
    sda_m = 1'b1;
    wait_clks(Q);
    scl_high(st);
    wait_clks(Q);
    sda_m = 1'b0;
    wait_clks(Q);
    scl_m = 1'b0;
    wait_clks(Q);
  endtask

  task automatic i2c_stop();
    int st;
    sda_m = 1'b0;
    wait_clks(Q);
    scl_high(st);
    wait_clks(Q);
    sda_m = 1'b1;
    wait_clks(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic acked);
    logic s;
    int   st;
    for (int i = 7; i >= 0; i--) clock_bit(d[i], s, st);
    clock_bit(1'b1, s, st);
    acked = (s == 1'b0);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d, output int st_total);
    logic s;
    int   st;
    st_total = 0;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s, st);
      d[i] = s;
      st_total += st;
    end
    clock_bit(nack, s, st);
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, 32'(bus.wr_valid_o), 32'd1);
    check({tag, "_data"}, 32'(bus.wr_data_o), 32'(exp));
    bus.wr_ready_i = 1'b1;
    wait_clks(1);
    bus.wr_ready_i = 1'b0;
  endtask

  initial begin
    logic       ack;
    logic       s;
    logic [7:0] rdat;
    int         st;
    int         snap_s, snap_p, snap_r, snap_l;

    bus.wr_ready_i = 1'b0;
    bus.rd_valid_i = 1'b0;
    bus.rd_data_i  = 8'h00;

    // reset state
    wait_clks(3);
    check("rst_scl_o",    32'(bus.scl_o),      32'd1);
    check("rst_sda_o",    32'(bus.sda_o),      32'd1);
    check("rst_wr_valid", 32'(bus.wr_valid_o), 32'd0);
    check("rst_wr_data",  32'(bus.wr_data_o),  32'd0);
    check("rst_rd_ready", 32'(bus.rd_ready_o), 32'd0);
    check("rst_busy",     32'(busy),           32'd0);
    check("rst_start",    32'(start),          32'd0);
    check("rst_stop",     32'(stop),           32'd0);
    check("rst_overrun",  32'(overrun),        32'd0);
    check("rst_op",       32'(op),             32'(I2C_WRITE));
    rst_n = 1'b1;
    wait_clks(10);
    check("no_start_on_release", 32'(start_cnt), 32'd0);
    check("no_stop_on_release",  32'(stop_cnt),  32'd0);

    // write 0xA5, 0x3C to 0x22
    snap_s = start_cnt;
    snap_p = stop_cnt;
    i2c_start();
    write_byte(8'h44, ack);
    check("wr_addr_ack", 32'(ack),  32'd1);
    check("wr_busy",     32'(busy), 32'd1);
    check("wr_op",       32'(op),   32'(I2C_WRITE));
    write_byte(8'hA5, ack);
    check("wr_b0_ack", 32'(ack), 32'd1);
    write_byte(8'h3C, ack);
    check("wr_b1_ack", 32'(ack), 32'd1);
    i2c_stop();
    wait_clks(4);
    check("wr_start_pulses", 32'(start_cnt - snap_s), 32'd1);
    check("wr_stop_pulses",  32'(stop_cnt - snap_p),  32'd1);
    check("wr_busy_after_stop", 32'(busy), 32'd0);
    pop_check("wr_pop0", 8'hA5);
    pop_check("wr_pop1", 8'h3C);
    check("wr_fifo_empty", 32'(bus.wr_valid_o), 32'd0);

    // write to wrong address 0x23
    i2c_start();
    write_byte(8'h46, ack);
    check("bad_addr_nack", 32'(ack),  32'd0);
    check("bad_addr_busy", 32'(busy), 32'd0);
    write_byte(8'h11, ack);
    check("bad_addr_data_nack", 32'(ack), 32'd0);
    i2c_stop();
    wait_clks(4);
    check("bad_addr_no_push", 32'(bus.wr_valid_o), 32'd0);

    // read from 0x22 with late rd_valid_i: clock stretching
    i2c_start();
    write_byte(8'h45, ack);
    check("rd_addr_ack", 32'(ack),  32'd1);
    check("rd_op",       32'(op),   32'(I2C_READ));
    check("rd_busy",     32'(busy), 32'd1);
    snap_r = rdy_cnt;
    fork
      read_byte(1'b1, rdat, st);
      begin
        int n;
        wait_clks(40);
        check("rd_stretch_scl_low", 32'(bus.scl_o), 32'd0);
        wait_clks(20);
        bus.rd_data_i  = 8'h5A;
        bus.rd_valid_i = 1'b1;
        n = 0;
        while (bus.rd_ready_o !== 1'b1 && n < 200) begin
          wait_clks(1);
          n++;
        end
        if (bus.rd_ready_o !== 1'b1) check("rd_ready_timeout", 32'(bus.rd_ready_o), 32'd1);
        bus.rd_valid_i = 1'b0;
      end
    join
    check("rd_data",         32'(rdat),             32'h5A);
    check("rd_stretch_ge50", 32'(st >= 50),          32'd1);
    check("rd_ready_pulses", 32'(rdy_cnt - snap_r),  32'd1);
    // controller NACKed: target must no longer load or drive
    bus.rd_data_i  = 8'h00;
    bus.rd_valid_i = 1'b1;
    snap_r = rdy_cnt;
    read_byte(1'b1, rdat, st);
    check("rd_ignore_data",  32'(rdat),            32'hFF);
    check("rd_ignore_nload", 32'(rdy_cnt - snap_r), 32'd0);
    bus.rd_valid_i = 1'b0;
    i2c_stop();
    wait_clks(4);
    check("rd_busy_after_stop", 32'(busy), 32'd0);

    // overrun: five bytes into a 4-deep FIFO with no pops
    i2c_start();
    write_byte(8'h44, ack);
    check("ovr_addr_ack", 32'(ack), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      write_byte(8'(i), ack);
      check("ovr_byte_ack", 32'(ack), 32'd1);
    end
    check("ovr_flag_before", 32'(overrun), 32'd0);
    write_byte(8'h05, ack);
    check("ovr_byte5_nack", 32'(ack),     32'd0);
    check("ovr_flag",       32'(overrun), 32'd1);
    i2c_stop();
    for (int i = 1; i <= 4; i++) pop_check("ovr_pop", 8'(i));
    check("ovr_fifo_empty", 32'(bus.wr_valid_o), 32'd0);
    check("ovr_sticky",     32'(overrun),        32'd1);

    // repeated START: write one byte then read
    snap_s = start_cnt;
    bus.rd_data_i  = 8'hC3;
    bus.rd_valid_i = 1'b1;
    i2c_start();
    write_byte(8'h44, ack);
    check("rs_addr_ack", 32'(ack), 32'd1);
    write_byte(8'h77, ack);
    check("rs_b0_ack", 32'(ack), 32'd1);
    i2c_start();
    write_byte(8'h45, ack);
    check("rs_raddr_ack", 32'(ack), 32'd1);
    check("rs_op_read",   32'(op),  32'(I2C_READ));
    read_byte(1'b1, rdat, st);
    check("rs_rd_data",    32'(rdat),  32'hC3);
    check("rs_no_stretch", 32'(st < 2), 32'd1);
    bus.rd_valid_i = 1'b0;
    i2c_stop();
    wait_clks(4);
    check("rs_start_pulses", 32'(start_cnt - snap_s), 32'd2);
    pop_check("rs_pop", 8'h77);

    // reset during bit 4 of a read
    bus.rd_data_i  = 8'h00;
    bus.rd_valid_i = 1'b1;
    i2c_start();
    write_byte(8'h45, ack);
    check("mrst_addr_ack", 32'(ack), 32'd1);
    repeat (3) clock_bit(1'b1, s, st);
    sda_m = 1'b1;
    wait_clks(Q);
    scl_high(st);
    wait_clks(Q / 2);
    check("mrst_sda_driven", 32'(bus.sda_o), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mrst_sda_rel", 32'(bus.sda_o), 32'd1);
    check("mrst_scl_rel", 32'(bus.scl_o), 32'd1);
    check("mrst_busy",    32'(busy),      32'd0);
    wait_clks(2);
    rst_n = 1'b1;
    bus.rd_valid_i = 1'b0;
    snap_l = sda_low_cnt;
    snap_s = start_cnt;
    wait_clks(Q / 2);
    scl_m = 1'b0;
    wait_clks(Q);
    repeat (5) clock_bit(1'b1, s, st);
    write_byte(8'h44, ack);
    check("mrst_no_ack",     32'(ack),                   32'd0);
    check("mrst_no_drive",   32'(sda_low_cnt - snap_l),  32'd0);
    check("mrst_no_start",   32'(start_cnt - snap_s),    32'd0);
    check("mrst_busy_after", 32'(busy),                  32'd0);
    i2c_start();
    write_byte(8'h44, ack);
    check("mrst_next_start_ack", 32'(ack), 32'd1);
    i2c_stop();
    wait_clks(4);
    check("mrst_fifo_empty", 32'(bus.wr_valid_o), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
